// File: rtl/xoro_prng_lanes_if.sv
// Seed-load and per-lane output stream bundle for xoro_prng_lanes.
// master: seed source / word consumer; slave: the generator.
interface xoro_prng_lanes_if #(
  parameter int LANES = 2,
  parameter int OUT_W = 32
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                   seed_we;
  logic [LW-1:0]          seed_lane;
  logic [63:0]            seed_s0;
  logic [63:0]            seed_s1;
  logic [LANES-1:0]       out_ready;
  logic [LANES-1:0]       out_valid;
  logic [LANES*OUT_W-1:0] out_data;

  modport master (
    output seed_we, seed_lane, seed_s0, seed_s1, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  seed_we, seed_lane, seed_s0, seed_s1, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/xoro_prng_lanes.sv
// Multi-lane xoroshiro128+ generator with per-lane valid/ready streams and reseed.
// Optional XORO_ZERO_GUARD_EN: an all-zero seed load restores that lane's reset seeds.
module xoro_prng_lanes #(
  parameter int          LANES = 2,
  parameter int          OUT_W = 32,
  parameter logic [63:0] SEED0 = 64'h0000_0000_0000_0001,
  parameter logic [63:0] SEED1 = 64'h0000_0000_0000_0002
) (
  input  logic               clk,
  input  logic               resn,
  xoro_prng_lanes_if.slave   bus
);

  logic [63:0]      s0_q   [LANES];
  logic [63:0]      s0_d   [LANES];
  logic [63:0]      s1_q   [LANES];
  logic [63:0]      s1_d   [LANES];
  logic [OUT_W-1:0] data_q [LANES];
  logic [OUT_W-1:0] data_d [LANES];
  logic [LANES-1:0] valid_q;
  logic [LANES-1:0] valid_d;

  logic [31:0] lane_sel;
  logic        seed_ok;

  function automatic logic [63:0] rst_s0(input int unsigned lane);
    return SEED0 ^ (64'(lane) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [63:0] next_s0(input logic [63:0] s0, input logic [63:0] s1);
    logic [63:0] t;
    t = s1 ^ s0;
    return {s0[39:0], s0[63:40]} ^ t ^ (t << 16);
  endfunction

  function automatic logic [63:0] next_s1(input logic [63:0] s0, input logic [63:0] s1);
    logic [63:0] t;
    t = s1 ^ s0;
    return {t[26:0], t[63:27]};
  endfunction

  function automatic logic [OUT_W-1:0] word_of(input logic [63:0] s0, input logic [63:0] s1);
    logic [63:0] sum;
    sum = s0 + s1;
    return sum[63 -: OUT_W];
  endfunction

  // Lane select widened so out-of-range lanes compare cleanly for any LANES.
  assign lane_sel = 32'(bus.seed_lane);
  assign seed_ok  = bus.seed_we && (lane_sel < 32'(LANES));

  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      s0_d[i]   = s0_q[i];
      s1_d[i]   = s1_q[i];
      data_d[i] = data_q[i];
      // Seed wins over a same-cycle handshake; the presented word is still consumed.
      if (seed_ok && lane_sel == 32'(i)) begin
        s0_d[i]    = bus.seed_s0;
        s1_d[i]    = bus.seed_s1;
`ifdef XORO_ZERO_GUARD_EN
        if (bus.seed_s0 == '0 && bus.seed_s1 == '0) begin
          s0_d[i] = rst_s0(i);
          s1_d[i] = SEED1;
        end
`endif
        valid_d[i] = 1'b0;
      end else if (!valid_q[i] || bus.out_ready[i]) begin
        s0_d[i]    = next_s0(s0_q[i], s1_q[i]);
        s1_d[i]    = next_s1(s0_q[i], s1_q[i]);
        data_d[i]  = word_of(s0_q[i], s1_q[i]);
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        s0_q[i]   <= rst_s0(i);
        s1_q[i]   <= SEED1;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        s0_q[i]   <= s0_d[i];
        s1_q[i]   <= s1_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    bus.out_valid = valid_q;
    bus.out_data  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      bus.out_data[i*OUT_W +: OUT_W] = data_q[i];
    end
  end

endmodule
